// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if
//   Bus bundle between the register-file dump reader and the outside world:
//   the spare asynchronous register-file read port and the valid/ready
//   byte stream, normally headed to the UART transmitter.
//
//   Signals:
//     rf_ra     [ADDR_W-1:0]  read address into the register file
//     rf_rd     [31:0]        combinational read data for rf_ra
//     out_data  [7:0]         byte being offered
//     out_valid               out_data is valid
//     out_ready               consumer accepts when valid && ready at an edge
//
//   Modports:
//     master  the dump reader (drives address and byte stream)
//     slave   register file + byte consumer
// ---------------------------------------------------------------------------
interface regfile_dump_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rf_ra;
    logic [31:0]       rf_rd;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rf_ra,
        input  rf_rd,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rf_ra,
        output rf_rd,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Debug reader for the CPU register file. On a start request it walks the
//   spare asynchronous read port over registers 0..NUM_REGS-1, captures each
//   32-bit value for one LOAD cycle and streams it out MSB first as four
//   bytes on a valid/ready interface. Never writes the register file.
//
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     start     one-cycle dump request, sampled only in IDLE
//     abort     synchronous cancel; returns to IDLE at the next edge
//     bus       regfile_dump_if.master (rf_ra/rf_rd, out_data/valid/ready)
//     busy      high in every state except IDLE
//     done      one-cycle pulse after the last byte is accepted
//
//   Parameters:
//     NUM_REGS  registers dumped (1..32)
//     ADDR_W    read address width
//
//   Optional build macro REGDUMP_HEADER_EN:
//     prefixes the stream with two header bytes, 8'hA5 then NUM_REGS[7:0].
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    regfile_dump_if.master bus,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
`ifdef REGDUMP_HEADER_EN
        , S_HDR
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
`ifdef REGDUMP_HEADER_EN
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] HDR_COUNT = 8'(NUM_REGS);
`endif

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;       // register currently being dumped
    logic [1:0]        byte_cnt;  // bytes accepted of the current word / header
    logic [31:0]       shift;     // captured register, top byte on the bus
    logic              accept;

    assign accept    = bus.out_valid && bus.out_ready;
    assign bus.rf_ra = idx;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef REGDUMP_HEADER_EN
                    state_nxt = S_HDR;
`else
                    state_nxt = S_LOAD;
`endif
                end
            end
`ifdef REGDUMP_HEADER_EN
            S_HDR: begin
                if (accept && byte_cnt == 2'd1) begin
                    state_nxt = S_LOAD;
                end
            end
`endif
            S_LOAD: state_nxt = S_SEND;
            S_SEND: begin
                if (accept && byte_cnt == 2'd3) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Cancel beats everything, including a same-cycle accept or a
        // start arriving in IDLE.
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Index, byte counter and shift register
    // -----------------------------------------------------------------------
    // NOTE: the 32-bit shift register is reset along with the control
    // flops; it is small and a clean zero keeps out_data defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else if (abort) begin
            idx      <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx      <= '0;
                    byte_cnt <= '0;
                end
`ifdef REGDUMP_HEADER_EN
                S_HDR: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
`endif
                S_LOAD: begin
                    // Same-cycle register-file writes land at this edge and
                    // are therefore not part of the captured value.
                    shift    <= bus.rf_rd;
                    byte_cnt <= '0;
                end
                S_SEND: begin
                    if (accept) begin
                        shift    <= {shift[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 && idx != LAST_IDX) begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    idx <= '0;
                end
                default: begin
                    idx      <= '0;
                    byte_cnt <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (Moore: depend on state and datapath only)
    // -----------------------------------------------------------------------
    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        case (state)
            S_SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = shift[31:24];
            end
`ifdef REGDUMP_HEADER_EN
            S_HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = byte_cnt[0] ? HDR_COUNT : HDR_MAGIC;
            end
`endif
            default: begin
                bus.out_valid = 1'b0;
                bus.out_data  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
//   Self-checking bench for regfile_dump. A register-file model returns
//   reg[i] = 32'h01020300 + i (reg 0 = 0). Byte positions in the tables are
//   body offsets; the header length is added when REGDUMP_HEADER_EN is set.
// ---------------------------------------------------------------------------
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
`ifdef REGDUMP_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int BODY  = 4 * NUM_REGS;
    localparam int TOTAL = BODY + HDR;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic rf_init;
    logic wr_en;

    logic [31:0] rf [NUM_REGS];
    logic [7:0]  got [$];

    int n_vec = 0;
    int n_err = 0;

    regfile_dump_if #(.ADDR_W(ADDR_W)) bus ();

    regfile_dump #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Register-file model: asynchronous read, write at the clock edge.
    assign bus.rf_rd = rf[bus.rf_ra];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= (i == 0) ? 32'h0 : 32'h01020300 + 32'(i);
            end
        end else if (wr_en && busy && !bus.out_valid && !done && bus.rf_ra == 5'd3) begin
            // Write lands at the closing edge of reg 3's LOAD cycle.
            rf[3] <= 32'hDEADBEEF;
        end
    end

    typedef struct {
        string      name;
        int         pos;
        logic [7:0] exp;
    } vec_t;

    vec_t basic_tab [16];
    vec_t wr_tab    [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int body_pos);
        logic [31:0] w;
        int r;
        r = body_pos / 4;
        w = (r == 0) ? 32'h0 : 32'h01020300 + 32'(r);
        return 8'(w >> (24 - 8 * (body_pos % 4)));
    endfunction

    function automatic logic bp_ready(input int c);
        if ((c % 40) >= 20 && (c % 40) < 30) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One dump attempt. Each iteration: at the falling edge sample the
    // outputs, then drive inputs for the next rising edge.
    //   mode 0: out_ready=1, mode 1: backpressure
    //   abort_pos: assert abort while that stream byte is being accepted
    //   stop_pos:  return (dump still running) once that many bytes are in
    task automatic run(input int mode, input int abort_pos, input int stop_pos,
                       input logic start_busy, input int max_cyc,
                       output int done_at, output logic aborted);
        logic       rdy;
        logic       prev_stall;
        logic [7:0] prev_data;
        got.delete();
        done_at    = -1;
        aborted    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", 32'(bus.out_data), 32'(prev_data));
                end
                if (done) begin
                    done_at = c;
                    start   = 1'b0;
                    abort   = 1'b0;
                    return;
                end
                if (stop_pos >= 0 && got.size() == stop_pos) begin
                    start = 1'b0;
                    abort = 1'b0;
                    return;
                end
            end
            rdy   = (mode == 1) ? bp_ready(c) : 1'b1;
            start = (c == 0) || (start_busy && busy && (c % 7) == 3);
            abort = (abort_pos >= 0) && bus.out_valid && rdy && (got.size() == abort_pos);
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) got.push_back(bus.out_data);
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            if (abort) begin
                aborted = 1'b1;
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(got.size()), 32'(TOTAL));
        if (got.size() == TOTAL) begin
            for (int i = 0; i < BODY; i++) begin
                check({name, "_byte"}, 32'(got[HDR + i]), 32'(exp_byte(i)));
            end
        end
    endtask

    initial begin
        int   done_at;
        logic aborted;

        basic_tab = '{
            '{"r0_b0", 0, 8'h00},   '{"r0_b1", 1, 8'h00},
            '{"r0_b2", 2, 8'h00},   '{"r0_b3", 3, 8'h00},
            '{"r1_b0", 4, 8'h01},   '{"r1_b1", 5, 8'h02},
            '{"r1_b2", 6, 8'h03},   '{"r1_b3", 7, 8'h01},
            '{"r10_b0", 40, 8'h01}, '{"r10_b1", 41, 8'h02},
            '{"r10_b2", 42, 8'h03}, '{"r10_b3", 43, 8'h0A},
            '{"r31_b0", 124, 8'h01}, '{"r31_b1", 125, 8'h02},
            '{"r31_b2", 126, 8'h03}, '{"r31_b3", 127, 8'h1F}
        };
        wr_tab = '{
            '{"wr_r3_b0", 12, 8'h01}, '{"wr_r3_b1", 13, 8'h02},
            '{"wr_r3_b2", 14, 8'h03}, '{"wr_r3_b3", 15, 8'h03},
            '{"wr_r4_b0", 16, 8'h01}, '{"wr_r4_b1", 17, 8'h02},
            '{"wr_r4_b2", 18, 8'h03}, '{"wr_r4_b3", 19, 8'h04}
        };

        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        wr_en         = 1'b0;
        rf_init       = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rf_init = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ra", 32'(bus.rf_ra), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic dump: table vectors, header, timing
        run(0, -1, -1, 1'b0, 400, done_at, aborted);
        check("basic_len", 32'(got.size()), 32'(TOTAL));
`ifdef REGDUMP_HEADER_EN
        if (got.size() >= 2) begin
            check("hdr_magic", 32'(got[0]), 32'h0000_00A5);
            check("hdr_count", 32'(got[1]), 32'h0000_0020);
        end
`endif
        if (got.size() == TOTAL) begin
            for (int i = 0; i < 16; i++) begin
                check(basic_tab[i].name, 32'(got[HDR + basic_tab[i].pos]), 32'(basic_tab[i].exp));
            end
        end
        // Start sampled at the first edge; done is visible in the 161st cycle.
        check("basic_done_cycle", 32'(done_at), 32'(161 + HDR));
        @(negedge clk);
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_idle", 32'(busy), 32'd0);

        // Backpressure
        run(1, -1, -1, 1'b0, 2000, done_at, aborted);
        check_stream("bp");
        check("bp_done_seen", 32'(done_at > 0), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Abort on the accept of reg 5 byte 1
        run(0, HDR + 21, -1, 1'b0, 400, done_at, aborted);
        check("abort_reached", 32'(aborted), 32'd1);
        check("abort_bytes", 32'(got.size()), 32'(HDR + 22));
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_ra", 32'(bus.rf_ra), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_no_done2", 32'(done), 32'd0);

        // Restart after abort begins at reg 0 byte 0
        run(0, -1, -1, 1'b0, 400, done_at, aborted);
        check_stream("restart");
        check("restart_done_cycle", 32'(done_at), 32'(161 + HDR));
        @(negedge clk);

        // Asynchronous reset during reg 17
        run(0, -1, HDR + 17 * 4 + 2, 1'b0, 400, done_at, aborted);
        check("rst17_ra", 32'(bus.rf_ra), 32'd17);
        check("rst17_valid", 32'(bus.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_ra", 32'(bus.rf_ra), 32'd0);
        check("arst_data", 32'(bus.out_data), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(busy || bus.out_valid), 32'd0);
        end

        // Start pulses while busy must not restart the dump
        run(0, -1, -1, 1'b1, 400, done_at, aborted);
        check_stream("start_busy");
        check("start_busy_done_cycle", 32'(done_at), 32'(161 + HDR));
        @(negedge clk);

        // Write to reg 3 during its LOAD cycle is not captured
        wr_en = 1'b1;
        run(0, -1, -1, 1'b0, 400, done_at, aborted);
        wr_en = 1'b0;
        check("wr_len", 32'(got.size()), 32'(TOTAL));
        if (got.size() == TOTAL) begin
            for (int i = 0; i < 8; i++) begin
                check(wr_tab[i].name, 32'(got[HDR + wr_tab[i].pos]), 32'(wr_tab[i].exp));
            end
        end
        @(negedge clk);
        rf_init = 1'b1;
        @(negedge clk);
        rf_init = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the CPU register file: on request, walks a read port across the register file and streams each 32-bit register out as bytes.
- Bytes leave on a valid/ready byte interface, normally toward the UART transmitter.
- Sits beside the datapath. It uses a spare asynchronous read port of the register file; it never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1 (legal range 1..32).
- ADDR_W, 5, width of the register read address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- abort  input  1  synchronous cancel of a dump in progress.
- rf_ra  output  ADDR_W  read address driven to the register-file read port.
- rf_rd  input  32  combinational read data returned for rf_ra.
- out_data  output  8  byte being offered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready at a rising edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, rf_ra=0, out_data=0, out_valid=0, busy=0, done=0, internal byte counter=0, shift register=0. Takes effect immediately, mid-dump included; the dump is not resumed.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - start=1 → LOAD with register index=0 and rf_ra=0.
  - start is level-sampled only in IDLE.
- LOAD (exactly one cycle):
  - rf_ra holds the current index.
  - At the edge, rf_rd is captured into a 32-bit shift register and the byte counter is cleared.
  - Next state is SEND.
- SEND:
  - out_valid=1 and out_data=shift[31:24]. Bytes go out MSB first (big-endian).
  - On accept: shift left by 8 and increment the byte counter.
  - On the 4th accept of a register:
    - if index==NUM_REGS-1 → DONE;
    - else increment index and rf_ra → LOAD.
  - While out_ready=0, out_data and out_valid hold stable. No change is allowed until accept.
- DONE: done=1 and busy=1 for one cycle, then IDLE. out_valid=0.
- Throughput: 5 cycles per register with out_ready held high (1 LOAD + 4 SEND). A full 32-register dump takes 160 cycles from the start edge to the last accept, with done on the next cycle.
- Snapshot semantics:
  - Each register is sampled in its own LOAD cycle; the dump is not atomic across registers.
  - A register-file write that lands in the same cycle as LOAD is not visible, because the read is combinational before the write edge.
- abort:
  - abort=1 in any non-IDLE state → IDLE at the next edge. out_valid drops, no done pulse, rf_ra returns to 0.
  - abort has priority over the SEND accept in the same cycle; that byte still counts as transferred on the bus.
  - abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- Register 0 is read through the port like any other register; its value is whatever the register file returns (0).
- The index counter never wraps, because the terminal compare at NUM_REGS-1 ends the dump. NUM_REGS=32 fits in ADDR_W=5 without overflow.

Optional Feature:
- Macro REGDUMP_HEADER_EN.
- When defined:
  - Adds a HDR state between IDLE and the first LOAD.
  - HDR offers out_data=8'hA5, then the byte NUM_REGS[7:0], each with the normal valid/ready handshake.
  - Total stream is 4*NUM_REGS+2 bytes.
  - abort in HDR behaves as in other states.
- When not defined: no HDR state, IDLE goes straight to LOAD, stream is 4*NUM_REGS bytes.

Test Plan:
- Basic dump:
  - Stimulus: register-file model preloaded with reg[i]=32'h01020300+i (reg0=0), out_ready=1, start pulse.
  - Required: 128 bytes; first four bytes 00 00 00 00; bytes 5-8 01 02 03 01; last four 01 02 03 1F; done one cycle after the 128th accept; total 161 cycles start→done.
- Backpressure:
  - Stimulus: out_ready toggled pseudo-randomly, including 10-cycle low stretches.
  - Required: out_data/out_valid stable while stalled; byte sequence identical to basic dump; no byte dropped or duplicated.
- Abort:
  - Stimulus: abort asserted on the 2nd byte of reg 5 (accept coincident).
  - Required: next cycle IDLE, busy=0, out_valid=0, rf_ra=0, no done.
  - Follow-up: a new start restarts at reg 0 byte 0.
- Async reset mid-dump:
  - Stimulus: rst_n low for 3 cycles during reg 17.
  - Required: outputs at reset values immediately, without waiting for a clock edge; after release, stays IDLE until start.
- Start while busy / concurrent write:
  - Stimulus: start pulses during SEND; in a separate run, the register-file model writes reg 3=32'hDEADBEEF in reg 3's LOAD cycle.
  - Required: no restart; the reg 3 bytes show the old value.
- REGDUMP_HEADER_EN defined:
  - Stimulus: same as basic dump.
  - Required: first bytes A5 20, then the 128-byte body; 130 bytes total; done after the last accept.
